// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller.
// Contents: FSM state encoding, register-zero constant, default mult/div latency.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StLdStall  = 2'd1,
    StMdWait   = 2'd2,
    StExcEntry = 2'd3
  } state_e;

  localparam logic [4:0]  RegZero          = 5'd0;
  localparam int unsigned MuldivLatDefault = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_busy_cnt.sv
// muldiv_busy_cnt: tracks how long the mult/div unit stays occupied.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   start_i  - a mult/div is launched this cycle (reloads the counter)
//   busy_o   - unit occupied
//   done_o   - last busy cycle: busy_o drops after this edge unless reloaded
module muldiv_busy_cnt
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = MuldivLatDefault,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(MULDIV_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      cnt_d  = LoadVal;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Busy stays up for the cycle in which the counter reads zero.
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0) && !start_i;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: ID-stage sequencer for PC, IF/ID and ID/EX.
// Handles load-use stalls, mult/div occupancy stalls, branch/jump flushes and
// exception/interrupt entry.
// Ports:
//   clk, reset (async, active-low)
//   ID_rs, ID_rt, ID_uses_rt, ID_is_muldiv   - ID instruction info
//   EX_MemRead, EX_rt                         - load in EX
//   muldiv_start                              - EX launches mult/div
//   jump_ID, branch_taken_EX, irq, exc        - control-flow events
//   irq_ack, PC_write, IF_ID_write, IF_ID_flush, IF_ID_pre_flush,
//   ID_EX_flush, pc_sel_exc, muldiv_busy      - pipeline controls
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = MuldivLatDefault,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rt,
  input  logic       ID_is_muldiv,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_rt,
  input  logic       muldiv_start,
  input  logic       jump_ID,
  input  logic       branch_taken_EX,
  input  logic       irq,
  input  logic       exc,
  output logic       irq_ack,
  output logic       PC_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       IF_ID_pre_flush,
  output logic       ID_EX_flush,
  output logic       pc_sel_exc,
  output logic       muldiv_busy
);

  state_e state_q, state_d;
  logic   irq_ack_q, irq_ack_d;
  logic   irq_seen_q, irq_seen_d;
  logic   pre_q;
  logic   wr_prev_q;
  logic   muldiv_done;
  logic   load_use, md_stall, irq_ok;

  muldiv_busy_cnt #(
    .MULDIV_LAT(MULDIV_LAT),
    .CNT_W     (CNT_W)
  ) u_busy_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .start_i(muldiv_start),
    .busy_o (muldiv_busy),
    .done_o (muldiv_done)
  );

  assign load_use = EX_MemRead && (EX_rt != RegZero) &&
                    ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
  // Once in MD_WAIT the held instruction is known to be mult/div-class.
  assign md_stall = muldiv_busy && (ID_is_muldiv || (state_q == StMdWait));
  // One acceptance per irq level; interrupts wait for a clean RUN cycle.
  assign irq_ok   = irq && !irq_seen_q && (state_q == StRun);

  always_comb begin
    state_d         = StRun;
    irq_ack_d       = 1'b0;
    PC_write        = 1'b1;
    IF_ID_write     = 1'b1;
    IF_ID_flush     = 1'b0;
    IF_ID_pre_flush = 1'b0;
    ID_EX_flush     = 1'b0;
    pc_sel_exc      = 1'b0;
    if (state_q == StExcEntry) begin
      pc_sel_exc      = 1'b1;
      IF_ID_flush     = 1'b1;
      ID_EX_flush     = 1'b1;
      IF_ID_pre_flush = pre_q;
    end else if (exc) begin
      state_d = StExcEntry;
    end else if (branch_taken_EX) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (irq_ok) begin
      state_d   = StExcEntry;
      irq_ack_d = 1'b1;
    end else if (jump_ID) begin
      IF_ID_flush = 1'b1;
    end else if (md_stall) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      // Leave on the last busy cycle so the first free cycle is already RUN.
      state_d     = muldiv_done ? StRun : StMdWait;
    end else if (load_use && (state_q == StRun)) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      state_d     = StLdStall;
    end
  end

  always_comb begin
    irq_seen_d = irq_seen_q;
    if (irq_ack_d) begin
      irq_seen_d = 1'b1;
    end else if ((state_q == StRun) && !irq) begin
      irq_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      irq_ack_q  <= 1'b0;
      irq_seen_q <= 1'b0;
      pre_q      <= 1'b0;
      wr_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      irq_ack_q  <= irq_ack_d;
      irq_seen_q <= irq_seen_d;
      // Return PC must back up one more slot if ID was being held.
      pre_q      <= (state_q == StLdStall) || (state_q == StMdWait) || !wr_prev_q;
      wr_prev_q  <= IF_ID_write;
    end
  end

  assign irq_ack = irq_ack_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
  logic       ID_uses_rt = 0, ID_is_muldiv = 0, EX_MemRead = 0, muldiv_start = 0;
  logic       jump_ID = 0, branch_taken_EX = 0, irq = 0, exc = 0;
  logic       irq_ack, PC_write, IF_ID_write, IF_ID_flush, IF_ID_pre_flush;
  logic       ID_EX_flush, pc_sel_exc, muldiv_busy;

  int checks = 0;
  int errors = 0;

  // {PC_write, IF_ID_write, IF_ID_flush, pre_flush, ID_EX_flush, pc_sel_exc, irq_ack, busy}
  logic [7:0] obs;
  assign obs = {PC_write, IF_ID_write, IF_ID_flush, IF_ID_pre_flush,
                ID_EX_flush, pc_sel_exc, irq_ack, muldiv_busy};

  localparam logic [7:0] Norm     = 8'hC0;
  localparam logic [7:0] LuStall  = 8'h08;
  localparam logic [7:0] MdStall  = 8'h09;
  localparam logic [7:0] Branch   = 8'hE8;
  localparam logic [7:0] Jump     = 8'hE0;
  localparam logic [7:0] ExcEnt   = 8'hEC;
  localparam logic [7:0] ExcEntPr = 8'hFC;
  localparam logic [7:0] IrqEnt   = 8'hEE;
  localparam logic [7:0] IrqEntPr = 8'hFE;

  pipeline_hazard_ctrl #(
    .MULDIV_LAT(4),
    .CNT_W     (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_uses_rt     (ID_uses_rt),
    .ID_is_muldiv   (ID_is_muldiv),
    .EX_MemRead     (EX_MemRead),
    .EX_rt          (EX_rt),
    .muldiv_start   (muldiv_start),
    .jump_ID        (jump_ID),
    .branch_taken_EX(branch_taken_EX),
    .irq            (irq),
    .exc            (exc),
    .irq_ack        (irq_ack),
    .PC_write       (PC_write),
    .IF_ID_write    (IF_ID_write),
    .IF_ID_flush    (IF_ID_flush),
    .IF_ID_pre_flush(IF_ID_pre_flush),
    .ID_EX_flush    (ID_EX_flush),
    .pc_sel_exc     (pc_sel_exc),
    .muldiv_busy    (muldiv_busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs = '0; ID_rt = '0; EX_rt = '0;
    ID_uses_rt = 0; ID_is_muldiv = 0; EX_MemRead = 0; muldiv_start = 0;
    jump_ID = 0; branch_taken_EX = 0; irq = 0; exc = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL reset_held got %h exp %h", obs, Norm);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      checks++;
      if (obs !== Norm) begin
        errors++; $display("FAIL idle_%0d got %h exp %h", i, obs, Norm);
      end
    end
  endtask

  task automatic test_load_use();
    tick();
    EX_MemRead = 1; EX_rt = 5'd5; ID_rs = 5'd5; #2;
    checks++;
    if (obs !== LuStall) begin
      errors++; $display("FAIL lu_rs_stall got %h exp %h", obs, LuStall);
    end
    // Hazard inputs still present: the second cycle must not stall again.
    tick(); #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL lu_one_bubble got %h exp %h", obs, Norm);
    end
    tick();
    EX_rt = 5'd0; ID_rs = 5'd0; #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL lu_reg_zero got %h exp %h", obs, Norm);
    end
    tick();
    EX_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd3; ID_uses_rt = 0; #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL lu_rt_unused got %h exp %h", obs, Norm);
    end
    tick();
    ID_uses_rt = 1; #2;
    checks++;
    if (obs !== LuStall) begin
      errors++; $display("FAIL lu_rt_stall got %h exp %h", obs, LuStall);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_muldiv();
    muldiv_start = 1; #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL md_start got %h exp %h", obs, Norm);
    end
    tick();
    muldiv_start = 0; ID_is_muldiv = 1;
    for (int c = 1; c <= 4; c++) begin
      #2;
      checks++;
      if (obs !== MdStall) begin
        errors++; $display("FAIL md_stall_c%0d got %h exp %h", c, obs, MdStall);
      end
      tick();
    end
    #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL md_release got %h exp %h", obs, Norm);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_jump();
    EX_MemRead = 1; EX_rt = 5'd5; ID_rs = 5'd5; branch_taken_EX = 1; #2;
    checks++;
    if (obs !== Branch) begin
      errors++; $display("FAIL br_over_lu got %h exp %h", obs, Branch);
    end
    tick();
    // Back in RUN: the still-present hazard stalls again.
    branch_taken_EX = 0; #2;
    checks++;
    if (obs !== LuStall) begin
      errors++; $display("FAIL br_then_run got %h exp %h", obs, LuStall);
    end
    tick();
    clear_inputs();
    tick();
    jump_ID = 1; #2;
    checks++;
    if (obs !== Jump) begin
      errors++; $display("FAIL jump got %h exp %h", obs, Jump);
    end
    tick();
    EX_MemRead = 1; EX_rt = 5'd9; ID_rs = 5'd9; #2;
    checks++;
    if (obs !== Jump) begin
      errors++; $display("FAIL jump_over_lu got %h exp %h", obs, Jump);
    end
    tick();
    branch_taken_EX = 1; #2;
    checks++;
    if (obs !== Branch) begin
      errors++; $display("FAIL br_over_jump got %h exp %h", obs, Branch);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_irq();
    irq = 1; #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL irq_sample got %h exp %h", obs, Norm);
    end
    tick(); #2;
    checks++;
    if (obs !== IrqEnt) begin
      errors++; $display("FAIL irq_entry got %h exp %h", obs, IrqEnt);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); #2;
      checks++;
      if (obs !== Norm) begin
        errors++; $display("FAIL irq_no_reack_%0d got %h exp %h", i, obs, Norm);
      end
    end
    irq = 0;
    tick();
    tick();
  endtask

  task automatic test_irq_md_wait();
    muldiv_start = 1;
    tick();
    muldiv_start = 0; ID_is_muldiv = 1;
    tick();
    irq = 1;
    for (int c = 2; c <= 4; c++) begin
      #2;
      checks++;
      if (obs !== MdStall) begin
        errors++; $display("FAIL irq_md_defer_c%0d got %h exp %h", c, obs, MdStall);
      end
      tick();
    end
    #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL irq_md_sample got %h exp %h", obs, Norm);
    end
    tick();
    ID_is_muldiv = 0; #2;
    checks++;
    if (obs !== IrqEntPr) begin
      errors++; $display("FAIL irq_md_entry got %h exp %h", obs, IrqEntPr);
    end
    tick();
    irq = 0;
    tick();
    tick();
  endtask

  task automatic test_exc();
    EX_MemRead = 1; EX_rt = 5'd4; ID_rs = 5'd4; exc = 1; #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL exc_over_lu got %h exp %h", obs, Norm);
    end
    tick();
    clear_inputs(); #2;
    checks++;
    if (obs !== ExcEnt) begin
      errors++; $display("FAIL exc_entry got %h exp %h", obs, ExcEnt);
    end
    tick();
    EX_MemRead = 1; EX_rt = 5'd4; ID_rs = 5'd4;
    tick();
    clear_inputs(); exc = 1;
    tick();
    exc = 0; #2;
    checks++;
    if (obs !== ExcEntPr) begin
      errors++; $display("FAIL exc_from_ld_stall got %h exp %h", obs, ExcEntPr);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_entry();
    irq = 1;
    tick(); #2;
    checks++;
    if (obs !== IrqEnt) begin
      errors++; $display("FAIL rst_pre_entry got %h exp %h", obs, IrqEnt);
    end
    reset = 1'b0; #1;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL rst_mid_entry got %h exp %h", obs, Norm);
    end
    irq = 0;
    tick();
    reset = 1'b1;
    tick(); #2;
    checks++;
    if (obs !== Norm) begin
      errors++; $display("FAIL rst_after got %h exp %h", obs, Norm);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_muldiv();
    test_branch_jump();
    test_irq();
    test_irq_md_wait();
    test_exc();
    test_reset_mid_entry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
